seq_det_reporter: RTL

SEQ_DET_REPORTER -- requirements
Module: seq_det_reporter

---
 rtl/seq_det_reporter_pkg.sv | 21 ++
 rtl/seq_det_reporter_if.sv | 51 +++++
 rtl/seq_det_reporter_fifo.sv | 79 +++++++
 rtl/seq_det_reporter.sv | 89 ++++++++
 4 files changed

// File: rtl/seq_det_reporter_pkg.sv
// Shared definitions for the sequence-detect event reporter: parameter
// defaults, the FIFO level-width helper and the per-edge FIFO control bundle.
package seq_det_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 16;
    localparam int DEPTH_DEF = 4;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Per-edge decision taken by the reporter for the event FIFO.
    typedef struct packed {
        logic push;   // detection stored at the tail
        logic pop;    // head consumed by downstream
        logic drop;   // detection lost because the FIFO was full
    } fifo_ctl_t;

endpackage

// File: rtl/seq_det_reporter_if.sv
// Bundle between the reporter and its environment: detection input, soft
// clear, and the timestamped event stream with status.
//
// Event handshake: ev_valid/ev_ts describe the FIFO head. A transfer happens
// on a rising clk edge where ev_valid=1 and ev_ready=1. While ev_valid=1 and
// ev_ready=0 the head (ev_ts) stays stable. ev_valid never depends on
// ev_ready, and ev_ready with ev_valid=0 does nothing.
interface seq_det_reporter_if
    import seq_det_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
);

    localparam int LVL_W = lvl_w(DEPTH);

    logic             det_pulse;
    logic             clr;
    logic             ev_ready;
    logic             ev_valid;
    logic [TS_W-1:0]  ev_ts;
    logic [CNT_W-1:0] det_count;
    logic             ovf;
    logic [LVL_W-1:0] level;

    // Environment side: drives detections, clear and consumer readiness.
    modport master (
        output det_pulse,
        output clr,
        output ev_ready,
        input  ev_valid,
        input  ev_ts,
        input  det_count,
        input  ovf,
        input  level
    );

    // Reporter side.
    modport slave (
        input  det_pulse,
        input  clr,
        input  ev_ready,
        output ev_valid,
        output ev_ts,
        output det_count,
        output ovf,
        output level
    );

endinterface

// File: rtl/seq_det_reporter_fifo.sv
// Synchronous event FIFO: power-of-two depth, wrapping pointers, explicit
// occupancy counter, synchronous flush. Push while full is accepted only when
// a pop happens on the same edge; pop while empty is ignored.
module det_evt_fifo
    import seq_det_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              wdata,
    output logic [W-1:0]              rdata,
    output logic [lvl_w(DEPTH)-1:0]   level,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = lvl_w(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Qualify requests against the current occupancy so the counter can
    // never overrun or underrun, whatever the caller asks for.
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
    end

    // Storage: cleared on reset so the head reads 0 until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; flush drops everything queued.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Status and head data come straight from registers.
    always_comb begin
        full  = (count == LVL_W'(DEPTH));
        empty = (count == '0);
        level = count;
        rdata = mem[rd_ptr];
    end

endmodule

// File: rtl/seq_det_reporter.sv
// Timestamps detections from the 10110 sequence detector, queues them in a
// small FIFO for a downstream consumer, counts all detections (saturating)
// and flags any detection lost to a full FIFO.
module seq_det_reporter
    import seq_det_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    seq_det_reporter_if.slave  bus
);

    localparam int               LVL_W   = lvl_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [TS_W-1:0]  ts_cnt;
    logic [CNT_W-1:0] det_count;
    logic             ovf;
    fifo_ctl_t        ctl;
    logic [TS_W-1:0]  fifo_rdata;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_full;
    logic             fifo_empty;

    // Free-running timestamp; soft clear intentionally leaves it alone so
    // timestamps stay monotonic across clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end

    // Decide push/pop/drop for this edge; clear suppresses both sides.
    always_comb begin
        ctl      = '0;
        ctl.pop  = ~bus.clr & bus.ev_ready & ~fifo_empty;
        ctl.push = ~bus.clr & bus.det_pulse & (~fifo_full | ctl.pop);
        ctl.drop = ~bus.clr & bus.det_pulse & fifo_full & ~ctl.pop;
    end

    // Saturating count of every detection, stored or dropped.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            det_count <= '0;
        end else if (bus.det_pulse && (det_count != CNT_MAX)) begin
            det_count <= det_count + CNT_W'(1);
        end
    end

    // Sticky overflow flag, set whenever a detection is lost.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            ovf <= 1'b0;
        end else if (ctl.drop) begin
            ovf <= 1'b1;
        end
    end

    det_evt_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.clr),
        .push  (ctl.push),
        .pop   (ctl.pop),
        .wdata (ts_cnt),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // All outputs are register-driven; no path from det_pulse to outputs.
    always_comb begin
        bus.ev_valid  = ~fifo_empty;
        bus.ev_ts     = fifo_rdata;
        bus.level     = fifo_level;
        bus.det_count = det_count;
        bus.ovf       = ovf;
    end

endmodule
